// File: rtl/mem_ctrl_fsm.sv
// mem_ctrl_fsm: sequencer for the external memory port with fixed strobe phases, ready wait, timeout and one-hot display state
module mem_ctrl_fsm #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int RESET_CYCLES = 3,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wr_data_in,
   input  logic              ack,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ce,
   output logic              mem_oe,
   output logic              mem_we,
   output logic [12:0]       state,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              err
);
   typedef enum logic [12:0] {
      RESET      = 13'h0001,
      IDLE       = 13'h0002,
      READ_ST0   = 13'h0004,
      READ_ST1   = 13'h0008,
      READ_ST2   = 13'h0010,
      READ_WAIT  = 13'h0020,
      READ_DONE  = 13'h0040,
      WRITE_ST0  = 13'h0080,
      WRITE_ST1  = 13'h0100,
      WRITE_ST2  = 13'h0200,
      WRITE_ST3  = 13'h0400,
      WRITE_ST4  = 13'h0800,
      WRITE_WAIT = 13'h1000
   } state_t;

   localparam int CW = $clog2((TIMEOUT > RESET_CYCLES ? TIMEOUT : RESET_CYCLES) + 1);
   localparam logic [12:0] CE_M = 13'h1FBC;
   localparam logic [12:0] OE_M = 13'h0038;
   localparam logic [12:0] WE_M = 13'h0600;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic              err_q, err_d, ce_q, oe_q, we_q;
   logic              to;

   assign to = cnt_q == CW'(TIMEOUT - 1);

   // next-state, latch and timeout-counter logic; the counter doubles as the reset-hold counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         RESET: begin
            state_d = (cnt_q == CW'(RESET_CYCLES - 1)) ? IDLE : RESET;
            cnt_d   = cnt_q + 1'b1;
         end
         IDLE: if (rd_req || wr_req) begin
            state_d = rd_req ? READ_ST0 : WRITE_ST0;
            addr_d  = addr_in;
            wdata_d = rd_req ? wdata_q : wr_data_in;
            err_d   = 1'b0;
         end
         READ_ST0:  state_d = READ_ST1;
         READ_ST1:  state_d = READ_ST2;
         READ_ST2: begin
            state_d = READ_WAIT;
            cnt_d   = '0;
         end
         READ_WAIT: if (mem_ready) begin
            state_d = READ_DONE;
            rdata_d = mem_rdata;
         end else if (to) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
         READ_DONE: state_d = ack ? IDLE : READ_DONE;
         WRITE_ST0: state_d = WRITE_ST1;
         WRITE_ST1: state_d = WRITE_ST2;
         WRITE_ST2: state_d = WRITE_ST3;
         WRITE_ST3: state_d = WRITE_ST4;
         WRITE_ST4: begin
            state_d = WRITE_WAIT;
            cnt_d   = '0;
         end
         WRITE_WAIT: if (mem_ready) state_d = IDLE;
         else if (to) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
         default: state_d = RESET;
      endcase
   end

   // state register with strobes registered from the next state so they align with it
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ce_q    <= 1'b0;
         oe_q    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ce_q    <= |(state_d & CE_M);
         oe_q    <= |(state_d & OE_M);
         we_q    <= |(state_d & WE_M);
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_ce    = ce_q;
   assign mem_oe    = oe_q;
   assign mem_we    = we_q;
   assign state     = state_q;
   assign rd_data   = rdata_q;
   assign busy      = ~state_q[1];
   assign err       = err_q;
endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// tb_mem_ctrl_fsm: directed-vector self-checking bench for mem_ctrl_fsm
module tb_mem_ctrl_fsm;
   logic        clk = 1'b0, reset, rd_req, wr_req, ack, mem_ready;
   logic [7:0]  addr_in, mem_addr;
   logic [15:0] wr_data_in, mem_rdata, mem_wdata, rd_data;
   logic        mem_ce, mem_oe, mem_we, busy, err;
   logic [12:0] state;
   int          n_chk = 0, n_fail = 0;

   localparam logic [12:0] RSEQ [7] = '{13'h0004, 13'h0008, 13'h0010, 13'h0020, 13'h0020, 13'h0020, 13'h0040};
   localparam logic [12:0] WSEQ [7] = '{13'h0080, 13'h0100, 13'h0200, 13'h0400, 13'h0800, 13'h1000, 13'h0002};
   localparam logic [12:0] TSEQ [8] = '{13'h0004, 13'h0008, 13'h0010, 13'h0020, 13'h0020, 13'h0020, 13'h0020, 13'h0002};

   always #5 clk = ~clk;

   mem_ctrl_fsm #(.ADDR_W(8), .DATA_W(16), .RESET_CYCLES(3), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr_in(addr_in),
      .wr_data_in(wr_data_in), .ack(ack), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ce(mem_ce), .mem_oe(mem_oe),
      .mem_we(mem_we), .state(state), .rd_data(rd_data), .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_release;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_hold", state, 13'h0001);
         chk("rst_busy", busy, 1'b1);
         tick;
      end
      chk("rst_idle", state, 13'h0002);
      chk("idle_busy", busy, 1'b0);
   endtask

   initial begin
      int oe_n, we_n;
      reset = 1'b1; rd_req = 0; wr_req = 0; ack = 0; mem_ready = 0;
      addr_in = 0; wr_data_in = 0; mem_rdata = 0;
      tick; tick;
      chk("reset_state", state, 13'h0001);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_err", err, 0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_wdata", mem_wdata, 0);
      chk("reset_strobes", {mem_ce, mem_oe, mem_we}, 3'b000);
      rst_release;

      addr_in = 8'h3C; rd_req = 1; mem_rdata = 16'hBEEF;
      tick;
      rd_req = 0; addr_in = 8'h00; oe_n = 0;
      for (int i = 0; i < 7; i++) begin
         chk("read_state", state, RSEQ[i]);
         chk("read_ce", mem_ce, (i < 6) ? 1'b1 : 1'b0);
         oe_n += mem_oe;
         if (i == 5) mem_ready = 1;
         if (i < 6) tick;
      end
      mem_ready = 0;
      chk("read_addr", mem_addr, 8'h3C);
      chk("read_data", rd_data, 16'hBEEF);
      chk("read_oe_cycles", oe_n, 5);
      tick;
      chk("read_done_hold", state, 13'h0040);
      ack = 1; tick; ack = 0;
      chk("read_ack_idle", state, 13'h0002);

      addr_in = 8'h12; wr_data_in = 16'hA5A5; wr_req = 1; mem_ready = 1;
      tick;
      wr_req = 0; addr_in = 8'h00; wr_data_in = 16'h0000; we_n = 0;
      for (int i = 0; i < 7; i++) begin
         chk("write_state", state, WSEQ[i]);
         we_n += mem_we;
         if (i < 6) begin
            chk("write_addr", mem_addr, 8'h12);
            chk("write_wdata", mem_wdata, 16'hA5A5);
            tick;
         end
      end
      chk("write_we_cycles", we_n, 2);
      chk("write_no_err", err, 0);

      rd_req = 1; wr_req = 1; addr_in = 8'h55; wr_data_in = 16'h1234; mem_rdata = 16'h0F0F;
      tick;
      rd_req = 0; wr_req = 0; we_n = 0;
      chk("both_state", state, 13'h0004);
      chk("both_addr", mem_addr, 8'h55);
      for (int i = 0; i < 4; i++) begin
         we_n += mem_we;
         tick;
      end
      chk("both_done", state, 13'h0040);
      chk("both_no_we", we_n, 0);
      chk("both_rd_data", rd_data, 16'h0F0F);
      chk("both_wdata_kept", mem_wdata, 16'hA5A5);
      ack = 1; tick; ack = 0;

      mem_ready = 0; mem_rdata = 16'hDEAD; addr_in = 8'h77; rd_req = 1;
      tick;
      rd_req = 0;
      for (int i = 0; i < 8; i++) begin
         chk("tmo_state", state, TSEQ[i]);
         if (i < 7) tick;
      end
      chk("tmo_err", err, 1);
      chk("tmo_rd_data", rd_data, 16'h0F0F);
      tick;
      chk("tmo_err_sticky", err, 1);
      rd_req = 1; mem_ready = 1;
      tick;
      rd_req = 0;
      chk("err_cleared", err, 0);
      tick; tick; tick; tick;
      chk("tmo_retry_done", state, 13'h0040);
      chk("tmo_retry_data", rd_data, 16'hDEAD);
      ack = 1; tick; ack = 0;

      addr_in = 8'h9A; wr_data_in = 16'h5A5A; wr_req = 1;
      tick;
      wr_req = 0;
      tick; tick;
      chk("mid_st2", state, 13'h0200);
      chk("mid_we", mem_we, 1);
      reset = 1;
      tick;
      chk("mid_rst_state", state, 13'h0001);
      chk("mid_rst_strobes", {mem_ce, mem_oe, mem_we}, 3'b000);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      chk("mid_rst_err", err, 0);
      rst_release;
      addr_in = 8'h21; rd_req = 1; mem_rdata = 16'hC0DE;
      tick;
      rd_req = 0;
      tick; tick; tick; tick;
      chk("resume_done", state, 13'h0040);
      chk("resume_data", rd_data, 16'hC0DE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_ctrl_fsm.md
# mem_ctrl_fsm

Sequencer for the external 16-bit memory port. It accepts single read or write requests, drives the memory strobes through fixed multi-cycle phases and waits for the memory's ready signal. It captures read data and publishes a 13-bit one-hot state vector plus read data for the seven-segment status display.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width (display path fixed at 16)
- RESET_CYCLES, 3, cycles spent in RESET after reset deasserts
- TIMEOUT, 255, max cycles in a WAIT state before abort (≥1)

- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  read request, sampled only in IDLE
- wr_req  in  1  write request, sampled only in IDLE
- addr_in  in  ADDR_W  request address
- wr_data_in  in  DATA_W  write data
- ack  in  1  releases READ_DONE
- mem_ready  in  1  memory transfer complete
- mem_rdata  in  DATA_W  memory read data
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_ce  out  1  chip enable
- mem_oe  out  1  output enable
- mem_we  out  1  write enable
- state  out  13  one-hot current state (display encoding)
- rd_data  out  DATA_W  last captured read data
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag

## Operation
- State encoding, one-hot, bit index: RESET 0, IDLE 1, READ_ST0 2, READ_ST1 3, READ_ST2 4, READ_WAIT 5, READ_DONE 6, WRITE_ST0 7, WRITE_ST1 8, WRITE_ST2 9, WRITE_ST3 10, WRITE_ST4 11, WRITE_WAIT 12. Exactly one bit is set at all times.
- RESET: entered and held while reset is high; the counter is cleared. After release, the FSM spends RESET_CYCLES cycles here, then goes to IDLE.
- IDLE: on rd_req, latch addr_in, clear err, go to READ_ST0. Otherwise on wr_req, latch addr_in and wr_data_in, clear err, go to WRITE_ST0. If both are high, read wins and the write is dropped.
- Read path: ST0 → ST1 → ST2 → READ_WAIT, unconditional. In READ_WAIT, when mem_ready is high, capture mem_rdata into rd_data and go to READ_DONE. READ_DONE holds until ack, then returns to IDLE.
- Write path: ST0 → ST1 → ST2 → ST3 → ST4 → WRITE_WAIT, unconditional. In WRITE_WAIT, mem_ready returns the FSM to IDLE.
- Strobes, decoded from the state register:
  - mem_ce = 1 in all READ_* and WRITE_* states except READ_DONE.
  - mem_oe = 1 in READ_ST1, READ_ST2, READ_WAIT.
  - mem_we = 1 in WRITE_ST2, WRITE_ST3.
  - Otherwise all 0.
- Timeout: a wait counter clears on entry to either WAIT state and increments each cycle mem_ready is low. On reaching TIMEOUT, the FSM goes to IDLE and sets err. rd_data is unchanged on a timeout.
- mem_ready in the same cycle the counter hits TIMEOUT counts as success; err is not set.
- rd_req, wr_req and ack outside their sampling states are ignored.
- mem_ready outside the WAIT states is ignored.

## Timing
- Reset values: state = 13'b1, rd_data = 0, err = 0, mem_addr = 0, mem_wdata = 0, mem_ce = mem_oe = mem_we = 0, busy = 1.
- A request sampled in IDLE at edge N puts the FSM in ST0 from N+1.
- Read with mem_ready already high: READ_WAIT at N+4, READ_DONE with valid rd_data at N+5.
- Write with mem_ready already high: WRITE_WAIT at N+6, IDLE at N+7.
- mem_we pulse is exactly 2 cycles. mem_addr and mem_wdata are stable from ST0 through the WAIT exit.
- ack in READ_DONE at edge M gives IDLE at M+1. A new request can be accepted at M+2.
- reset mid-operation: next edge gives state = RESET and all strobes 0. mem_addr, mem_wdata, rd_data and err return to reset values.

## Test plan
- Reset sequence: hold reset 2 cycles, then release. state = 0x0001 for exactly 3 cycles, then 0x0002; busy falls in the same cycle.
- Read: addr_in = 0x3C, rd_req for 1 cycle, mem_ready high on the 3rd READ_WAIT cycle with mem_rdata = 0xBEEF. Expect the state sequence 0x0004, 0x0008, 0x0010, 0x0020 ×3, 0x0040; rd_data = 0xBEEF; mem_oe high for 5 cycles. ack then returns the FSM to 0x0002.
- Write: addr 0x12, data 0xA5A5, mem_ready tied high. Expect states 0x0080 → 0x1000 → 0x0002; mem_we high for exactly 2 cycles with mem_wdata = 0xA5A5 and mem_addr = 0x12 throughout.
- Simultaneous rd_req and wr_req in IDLE: the read path is taken and the write is never issued (mem_we stays 0).
- Timeout with TIMEOUT = 4: read with mem_ready held low. Expect 4 READ_WAIT cycles, then IDLE, err = 1, rd_data unchanged. The next rd_req clears err.
- Reset asserted in WRITE_ST2 while mem_we = 1: on the next edge mem_we = 0 and state = 0x0001. After release, normal operation resumes after 3 cycles.
